// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss fill controller for the data/metadata way arrays.
// Define CACHE_FILL_CWF_EN to fetch and write the missed word first.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  memory_data_valid,
  input  logic [DATA_WIDTH-1:0] memory_data,
  output logic                  fsm_busy,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic [63:0]           set_enable,
  output logic [7:0]            word_enable,
  output logic                  write_data_array,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  write_tag_array,
  output logic [7:0]            tag_data,
  output logic                  fill_done
);

`ifdef CACHE_FILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_META
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:1] addr_q;
  logic [2:0]            req_cnt;
  logic [3:0]            rcv_cnt;
  logic                  req_done;

  logic                  accept;
  logic [3:0]            rcv_next;
  logic [2:0]            word_idx;
  logic                  to_meta;
  logic [5:0]            tag_bits;

  function automatic logic [2:0] order(
    input logic [2:0] i,
    input logic [2:0] off
  );
    return CWF ? 3'(off + i) : i;
  endfunction

  // Tag bits above the address width read as zero.
  for (genvar k = 0; k < 6; k++) begin : g_tag
    if (10 + k < ADDR_WIDTH) begin : g_in
      assign tag_bits[k] = addr_q[10+k];
    end else begin : g_out
      assign tag_bits[k] = 1'b0;
    end
  end

  // Words beyond the eighth, or outside a fill, are dropped.
  assign accept = memory_data_valid
                & ((state == S_REQ) | (state == S_WAIT))
                & ~rcv_cnt[3];

  assign rcv_next = rcv_cnt + {3'b000, accept};
  assign word_idx = order(rcv_cnt[2:0], addr_q[3:1]);

  assign to_meta = rcv_next[3]
                 & (((state == S_REQ) & (req_cnt == 3'd7))
                  | ((state == S_WAIT) & req_done));

  assign write_data_array = accept;
  assign word_enable      = accept ? (8'h01 << word_idx) : 8'h00;
  assign fill_data        = accept ? memory_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      addr_q          <= '0;
      req_cnt         <= '0;
      rcv_cnt         <= '0;
      req_done        <= 1'b0;
      fsm_busy        <= 1'b0;
      mem_read_en     <= 1'b0;
      memory_address  <= '0;
      set_enable      <= '0;
      write_tag_array <= 1'b0;
      tag_data        <= '0;
      fill_done       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (miss_detected) begin
            state          <= S_REQ;
            addr_q         <= miss_address[ADDR_WIDTH-1:1];
            req_cnt        <= '0;
            rcv_cnt        <= '0;
            req_done       <= 1'b0;
            fsm_busy       <= 1'b1;
            mem_read_en    <= 1'b1;
            memory_address <= {miss_address[ADDR_WIDTH-1:4],
                               order(3'd0, miss_address[3:1]),
                               1'b0};
            set_enable     <= 64'(1) << miss_address[9:4];
          end
        end
        S_REQ: begin
          rcv_cnt <= rcv_next;
          req_cnt <= req_cnt + 3'd1;
          if (req_cnt == 3'd7) begin
            req_done       <= 1'b1;
            mem_read_en    <= 1'b0;
            memory_address <= '0;
            state          <= S_WAIT;
          end else begin
            memory_address <= {addr_q[ADDR_WIDTH-1:4],
                               order(req_cnt + 3'd1, addr_q[3:1]),
                               1'b0};
          end
        end
        S_WAIT: begin
          rcv_cnt <= rcv_next;
        end
        S_META: begin
          state           <= S_IDLE;
          fsm_busy        <= 1'b0;
          set_enable      <= '0;
          write_tag_array <= 1'b0;
          tag_data        <= '0;
          fill_done       <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      // Last word landed with all requests out: commit metadata.
      if (to_meta) begin
        state           <= S_META;
        req_done        <= 1'b1;
        mem_read_en     <= 1'b0;
        memory_address  <= '0;
        write_tag_array <= 1'b1;
        fill_done       <= 1'b1;
        tag_data        <= {2'b10, tag_bits};
      end
    end
  end

endmodule
